// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/kill, decode handshake.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module fetch_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc,
  input  logic             if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic             fetch_misalign
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    HOLD,
    HALT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] req_pc_q;
  logic             kill_q;
  logic             if_valid_q;
  logic [31:0]      if_instr_q;
  logic [WIDTH-1:0] if_pc_q;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] tgt_pc;
  logic             redir;

  assign pc_inc = pc_q + WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  logic trap;
  assign tgt_pc = redirect_pc;
  assign trap   = redirect_valid && (redirect_pc[1:0] != 2'b00)
                  && (state_q != HALT);
  assign redir  = redirect_valid && !trap;
  assign fetch_misalign = misalign_q;
`else
  // Low address bits are not meaningful for 32-bit fetch; force them to zero.
  assign tgt_pc = {redirect_pc[WIDTH-1:2], 2'b00};
  assign redir  = redirect_valid;
`endif

  assign imem_req  = (state_q == REQ);
  assign imem_addr = (state_q == REQ) ? pc_q : '0;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= trap;
      if (trap) begin
        if_valid_q <= 1'b0;
        kill_q     <= 1'b0;
        state_q    <= HALT;
      end else
`endif
      unique case (state_q)
        IDLE: begin
          if (redir) pc_q <= tgt_pc;
          state_q <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            req_pc_q <= pc_q;
            pc_q     <= redir ? tgt_pc : pc_inc;
            kill_q   <= redir;
            state_q  <= RESP;
          end else if (redir) begin
            pc_q <= tgt_pc;
          end
        end
        RESP: begin
          if (redir) pc_q <= tgt_pc;
          if (imem_rvalid) begin
            // Stale (killed) or redirected-over data is dropped.
            if (!kill_q && !redir) begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= req_pc_q;
              if_valid_q <= 1'b1;
              state_q    <= HOLD;
            end else begin
              state_q <= REQ;
            end
            kill_q <= 1'b0;
          end else if (redir) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redir || if_ready) begin
            if (redir) pc_q <= tgt_pc;
            if_valid_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
// Covers reset, sequential fetch, stall, redirects, wrap and misalign handling.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int checks;
  int errors;

  fetch_sequencer #(
    .WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_ready(if_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if_ready = 1'b0;
    cyc();
    cyc();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b want 0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_addr got %h want 0", imem_addr);
    end
    checks++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_if got v=%b i=%h pc=%h want 0/0/0",
               if_valid, if_instr, if_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] ins;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ins = 32'h1000_0000 + 32'(k);
      cyc();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_req%0d got req=%b addr=%h want 1/%h",
                 k, imem_req, imem_addr, 32'(4 * k));
      end
      imem_rdata = ins;
      cyc();
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_resp%0d got req=%b v=%b want 0/0",
                 k, imem_req, if_valid);
      end
      cyc();
      checks++;
      if (if_valid !== 1'b1 || if_instr !== ins || if_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_out%0d got v=%b i=%h pc=%h want 1/%h/%h",
                 k, if_valid, if_instr, if_pc, ins, 32'(4 * k));
      end
    end
  endtask

  task automatic test_hold_stall();
    if_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++;
      if (if_valid !== 1'b1 || if_instr !== 32'h1000_0002 ||
          if_pc !== 32'h8 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got v=%b i=%h pc=%h req=%b want 1/10000002/8/0",
                 c, if_valid, if_instr, if_pc, imem_req);
      end
    end
    if_ready = 1'b1;
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_rel got req=%b addr=%h v=%b want 1/c/0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_redirect_resp();
    cyc();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_wait got req=%b v=%b want 0/0", imem_req, if_valid);
    end
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rr_drop got v=%b req=%b addr=%h want 0/1/100",
               if_valid, imem_req, imem_addr);
    end
    imem_rdata = 32'h3333_0003;
    cyc();
    cyc();
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h3333_0003 || if_pc !== 32'h100) begin
      errors++;
      $display("FAIL rr_next got v=%b i=%h pc=%h want 1/33330003/100",
               if_valid, if_instr, if_pc);
    end
    cyc();
    checks++;
    if (imem_addr !== 32'h104) begin
      errors++; $display("FAIL rr_inc got %h want 104", imem_addr);
    end
  endtask

  task automatic test_redirect_gnt();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL rg_nognt got req=%b addr=%h want 1/8", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    imem_rdata = 32'hBAD0_0008;
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rg_drop got v=%b req=%b addr=%h want 0/1/200",
               if_valid, imem_req, imem_addr);
    end
    imem_rdata = 32'h4444_0004;
    cyc();
    cyc();
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h4444_0004 || if_pc !== 32'h200) begin
      errors++;
      $display("FAIL rg_next got v=%b i=%h pc=%h want 1/44440004/200",
               if_valid, if_instr, if_pc);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req got v=%b addr=%h want 0/fffffffc",
               if_valid, imem_addr);
    end
    redirect_valid = 1'b0;
    imem_rdata = 32'h5555_0005;
    cyc();
    cyc();
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h5555_0005) begin
      errors++;
      $display("FAIL wrap_out got pc=%h i=%h want fffffffc/55550005",
               if_pc, if_instr);
    end
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    cyc();
    cyc();
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL rh got v=%b req=%b addr=%h want 0/1/40",
               if_valid, imem_req, imem_addr);
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 ||
        if_valid !== 1'b0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL rm_rst got req=%b addr=%h v=%b pc=%h want 0/0/0/0",
               imem_req, imem_addr, if_valid, if_pc);
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    rst = 1'b0;
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_req got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rm_ign got v=%b req=%b want 0/1", if_valid, imem_req);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    cyc();
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse got m=%b req=%b want 1/0", fetch_misalign, imem_req);
    end
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    checks++;
    if (fetch_misalign !== 1'b0) begin
      errors++; $display("FAIL mis_once got %b want 0", fetch_misalign);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis_halt%0d got req=%b v=%b want 0/0", c, imem_req, if_valid);
      end
    end
`else
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL mis_mask got req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
    redirect_valid = 1'b0;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_resp();
    test_redirect_gnt();
    test_wrap();
    test_redirect_hold();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  WIDTH  redirect target
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  WIDTH  fetch address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_instr  out  32  fetched instruction
- if_pc  out  WIDTH  address of if_instr
- if_ready  in  1  decode accepts the instruction

Function
REQ-004 The FSM SHALL have states IDLE, REQ, RESP and HOLD; IDLE SHALL move to REQ unconditionally one cycle after reset release.
REQ-005 Register pc SHALL hold the next fetch address; in REQ, imem_req=1 and imem_addr=pc; imem_req SHALL be 0 in all other states.
REQ-006 In REQ, imem_gnt=1 SHALL latch req_pc<=pc, update pc<=pc+4 (modulo 2^WIDTH, wraps to 0) and move to RESP.
REQ-007 At most one request SHALL be outstanding; imem_req SHALL NOT assert while in RESP.
REQ-008 In RESP, imem_rvalid=1 with kill=0 SHALL load if_instr<=imem_rdata and if_pc<=req_pc, set if_valid, and move to HOLD.
REQ-009 In RESP, imem_rvalid=1 with kill=1 SHALL discard the data, clear kill and move to REQ.
REQ-010 In HOLD, if_valid, if_instr and if_pc SHALL stay stable until if_ready=1; the handshake SHALL clear if_valid and move to REQ.
REQ-011 A redirect SHALL have priority over the pc+4 increment in every state and SHALL set pc<=redirect_pc.
REQ-012 A redirect in REQ without imem_gnt SHALL stay in REQ; the next cycle SHALL present the new pc.
REQ-013 A redirect in REQ with imem_gnt SHALL still move to RESP, with kill=1.
REQ-014 A redirect in RESP SHALL set kill=1; a redirect coinciding with a kill=0 response SHALL discard that response and move to REQ.
REQ-015 A redirect in HOLD SHALL clear if_valid next cycle and move to REQ; redirect coinciding with if_ready SHALL count as consumed and move to REQ.
REQ-016 imem_rvalid outside RESP SHALL be ignored.
REQ-017 Minimum latency SHALL be: request at cycle N, gnt at N, rvalid at N+1, if_valid at N+2.

Reset
REQ-018 While rst=1 the block SHALL force pc=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0.
REQ-019 Reset mid-operation SHALL abandon any outstanding request; a post-reset rvalid before the first new grant SHALL be ignored.

Configuration
REQ-020 With macro FETCH_MISALIGN_TRAP_EN defined, the block SHALL add output fetch_misalign (1 bit, reset 0).
REQ-021 With FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL:
- pulse fetch_misalign for exactly one cycle;
- clear if_valid;
- leave pc unchanged;
- enter state HALT, issuing no requests until reset.
REQ-022 Without FETCH_MISALIGN_TRAP_EN, the fetch_misalign port SHALL NOT exist and redirect_pc[1:0] SHALL be treated as 2'b00.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset release, gnt always 1, rvalid one cycle after gnt, if_ready=1 -> imem_addr 0x0, 0x4, 0x8 in order; if_pc matches; first if_valid at cycle 3 after release.
- if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, imem_req=0 throughout.
- Redirect to 0x100 in RESP, then rvalid with 0xDEADBEEF -> no if_valid for that data; next imem_addr=0x100.
- Redirect to 0x200 in the same cycle as gnt for 0x8 -> response for 0x8 dropped; next request 0x200.
- pc=0xFFFFFFFC fetched -> next imem_addr=0x0.
- FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 -> fetch_misalign high one cycle; no further imem_req until rst.
